// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared register map, CTRL bit layout, FSM state and byte-phase
// encodings for the spi_seq register-level SPI sequencer.
package spi_seq_pkg;

    // Peripheral register offsets
    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_DATA   = 8'h04;
    localparam logic [7:0] OFF_STATUS = 8'h08;

    // Byte-lane selects
    localparam logic [3:0] SEL_DATA = 4'b0001;
    localparam logic [3:0] SEL_CTRL = 4'b0011;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_CPOL    = 1;
    localparam int CTRL_CPHA    = 2;
    localparam int CTRL_CS      = 3;
    localparam int CTRL_DIV_LSB = 8;

    // STATUS bit positions
    localparam int STAT_BUSY = 0;

    typedef enum logic [2:0] {
        IDLE, LOAD, START, WAIT, POLL, FETCH, CS_OFF, FIN
    } state_e;

    typedef enum logic [2:0] {
        PH_CMD, PH_A2, PH_A1, PH_A0, PH_DATA
    } phase_e;

    // CTRL word: on=1 starts a byte with CS held, on=0 drops CS and EN.
    function automatic logic [31:0] ctrl_word(input logic [7:0] div,
                                              input logic       cpha,
                                              input logic       cpol,
                                              input logic       on);
        logic [31:0] w;
        w = '0;
        w[CTRL_DIV_LSB +: 8] = div;
        w[CTRL_CPHA]         = cpha;
        w[CTRL_CPOL]         = cpol;
        w[CTRL_CS]           = on;
        w[CTRL_EN]           = on;
        return w;
    endfunction

endpackage

// File: rtl/spi_seq_timer.sv
// spi_seq_timer: POLL timeout counter, only instantiated when
// SPI_SEQ_TIMEOUT_EN is defined.
// Ports: clk, rst_n (async low); run_i counts while high, clears while low;
//        expired_o high in the TIMEOUT-th consecutive run cycle.
module spi_seq_timer #(
    parameter logic [15:0] TIMEOUT = 16'd4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    output logic expired_o
);

    logic [15:0] cnt_q;

    assign expired_o = run_i && (({1'b0, cnt_q} + 17'd1) >= {1'b0, TIMEOUT});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cnt_q <= '0;
        else if (!run_i)     cnt_q <= '0;
        else if (!expired_o) cnt_q <= cnt_q + 16'd1;
    end

endmodule

// File: rtl/spi_seq.sv
// spi_seq: sequences a command/address/data SPI transaction through a
// register-mapped SPI peripheral (CTRL/DATA/STATUS), one byte at a time,
// holding CS across the whole transaction.
// Ports: clk, rst_n (async low); req_* transaction request; tx_* write bytes
//        in; rx_* read bytes out; busy/done/err status; spi_* register master.
// Build option: SPI_SEQ_TIMEOUT_EN adds a POLL timeout that aborts with err.
module spi_seq
    import spi_seq_pkg::*;
#(
    parameter logic [7:0]  DIV     = 8'd0,
    parameter logic        CPOL    = 1'b0,
    parameter logic        CPHA    = 1'b0,
    parameter logic [15:0] TIMEOUT = 16'd4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [23:0] req_addr,
    input  logic        req_addr_en,
    input  logic        req_wr,
    input  logic [7:0]  req_len,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [7:0]  tx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [7:0]  rx_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  spi_waddr_o,
    output logic [31:0] spi_wdata_o,
    output logic [3:0]  spi_sel_o,
    output logic        spi_we_o,
    output logic [7:0]  spi_raddr_o,
    output logic        spi_rd_o,
    input  logic [31:0] spi_rdata_i
);

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d, adv_phase;
    logic [7:0]  cmd_q, cmd_d, len_q, len_d, cnt_q, cnt_d, adv_cnt, cur_byte;
    logic [23:0] addr_q, addr_d;
    logic        addr_en_q, addr_en_d, wr_q, wr_d, adv_last;
    logic [1:0]  wcnt_q, wcnt_d;
    logic        pend_q, pend_d;          // register read issued, data due this cycle
    logic        rxv_q, rxv_d;
    logic [7:0]  rxd_q, rxd_d;
    logic        rdy_q, rdy_d;
    logic        wr_phase;
    logic        unused_rdata;

    assign unused_rdata = ^spi_rdata_i[31:8];

`ifdef SPI_SEQ_TIMEOUT_EN
    logic tmo_hit, abort_q, abort_d;
    spi_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_i     (state_q == POLL),
        .expired_o (tmo_hit)
    );
`else
    localparam logic [15:0] unused_timeout = TIMEOUT;
`endif

    assign req_ready = rdy_q;
    assign rx_valid  = rxv_q;
    assign rx_data   = rxd_q;
    assign wr_phase  = (phase_q == PH_DATA) && wr_q;

    always_comb begin
        case (phase_q)
            PH_CMD:  cur_byte = cmd_q;
            PH_A2:   cur_byte = addr_q[23:16];
            PH_A1:   cur_byte = addr_q[15:8];
            PH_A0:   cur_byte = addr_q[7:0];
            default: cur_byte = wr_q ? tx_data : 8'hFF;
        endcase
    end

    // Where to go once the current byte is fully finished.
    always_comb begin
        adv_phase = phase_q;
        adv_cnt   = cnt_q;
        adv_last  = 1'b0;
        case (phase_q)
            PH_CMD: begin
                if (addr_en_q)            adv_phase = PH_A2;
                else if (len_q != 8'd0) begin adv_phase = PH_DATA; adv_cnt = '0; end
                else                      adv_last = 1'b1;
            end
            PH_A2: adv_phase = PH_A1;
            PH_A1: adv_phase = PH_A0;
            PH_A0: begin
                if (len_q != 8'd0) begin adv_phase = PH_DATA; adv_cnt = '0; end
                else                 adv_last = 1'b1;
            end
            default: begin
                // compare against len-1 so len=255 never needs a 9-bit count
                if (cnt_q == len_q - 8'd1) adv_last = 1'b1;
                else                       adv_cnt  = cnt_q + 8'd1;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        addr_en_d = addr_en_q;
        wr_d      = wr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        wcnt_d    = wcnt_q;
        pend_d    = pend_q;
        rxv_d     = rxv_q;
        rxd_d     = rxd_q;
`ifdef SPI_SEQ_TIMEOUT_EN
        abort_d   = abort_q;
`endif
        spi_we_o    = 1'b0;
        spi_waddr_o = '0;
        spi_wdata_o = '0;
        spi_sel_o   = '0;
        spi_rd_o    = 1'b0;
        spi_raddr_o = '0;
        tx_ready    = 1'b0;
        busy        = (state_q != IDLE);
        done        = 1'b0;
        err         = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && rdy_q) begin
                    cmd_d     = req_cmd;
                    addr_d    = req_addr;
                    addr_en_d = req_addr_en;
                    wr_d      = req_wr;
                    len_d     = req_len;
                    cnt_d     = '0;
                    phase_d   = PH_CMD;
`ifdef SPI_SEQ_TIMEOUT_EN
                    abort_d   = 1'b0;
`endif
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                tx_ready = wr_phase;
                if (!wr_phase || tx_valid) begin
                    spi_we_o    = 1'b1;
                    spi_waddr_o = OFF_DATA;
                    spi_wdata_o = {24'h0, cur_byte};
                    spi_sel_o   = SEL_DATA;
                    state_d     = START;
                end
            end
            START: begin
                spi_we_o    = 1'b1;
                spi_waddr_o = OFF_CTRL;
                spi_wdata_o = ctrl_word(DIV, CPHA, CPOL, 1'b1);
                spi_sel_o   = SEL_CTRL;
                wcnt_d      = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                // peripheral busy flag is not valid until 3 cycles after start
                wcnt_d = wcnt_q + 2'd1;
                if (wcnt_q == 2'd2) begin
                    pend_d  = 1'b0;
                    state_d = POLL;
                end
            end
            POLL: begin
                if (pend_q && !spi_rdata_i[STAT_BUSY]) begin
                    pend_d = 1'b0;
                    if (phase_q == PH_DATA && !wr_q) state_d = FETCH;
                    else begin
                        phase_d = adv_phase;
                        cnt_d   = adv_cnt;
                        state_d = adv_last ? CS_OFF : LOAD;
                    end
                end
`ifdef SPI_SEQ_TIMEOUT_EN
                else if (tmo_hit) begin
                    pend_d  = 1'b0;
                    abort_d = 1'b1;
                    state_d = CS_OFF;
                end
`endif
                else if (!pend_q) begin
                    spi_rd_o    = 1'b1;
                    spi_raddr_o = OFF_STATUS;
                    pend_d      = 1'b1;
                end else begin
                    pend_d = 1'b0;
                end
            end
            FETCH: begin
                if (rxv_q) begin
                    if (rx_ready) begin
                        rxv_d   = 1'b0;
                        phase_d = adv_phase;
                        cnt_d   = adv_cnt;
                        state_d = adv_last ? CS_OFF : LOAD;
                    end
                end else if (pend_q) begin
                    rxd_d  = spi_rdata_i[7:0];
                    rxv_d  = 1'b1;
                    pend_d = 1'b0;
                end else begin
                    spi_rd_o    = 1'b1;
                    spi_raddr_o = OFF_DATA;
                    pend_d      = 1'b1;
                end
            end
            CS_OFF: begin
                spi_we_o    = 1'b1;
                spi_waddr_o = OFF_CTRL;
                spi_wdata_o = ctrl_word(DIV, CPHA, CPOL, 1'b0);
                spi_sel_o   = SEL_CTRL;
                state_d     = FIN;
            end
            default: begin // FIN
`ifdef SPI_SEQ_TIMEOUT_EN
                done = !abort_q;
                err  = abort_q;
`else
                done = 1'b1;
`endif
                state_d = IDLE;
            end
        endcase
        // registered so ready stays low through reset and the first edge after
        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= PH_CMD;
            cmd_q     <= '0;
            addr_q    <= '0;
            addr_en_q <= 1'b0;
            wr_q      <= 1'b0;
            len_q     <= '0;
            cnt_q     <= '0;
            wcnt_q    <= '0;
            pend_q    <= 1'b0;
            rxv_q     <= 1'b0;
            rxd_q     <= '0;
            rdy_q     <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
            abort_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            addr_en_q <= addr_en_d;
            wr_q      <= wr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            wcnt_q    <= wcnt_d;
            pend_q    <= pend_d;
            rxv_q     <= rxv_d;
            rxd_q     <= rxd_d;
            rdy_q     <= rdy_d;
`ifdef SPI_SEQ_TIMEOUT_EN
            abort_q   <= abort_d;
`endif
        end
    end

endmodule

// File: doc/spi_seq.md
SPI_SEQ -- requirements
Module: spi_seq

Interface
REQ-001 SHALL have parameters: DIV, 8'd0, SPI clock divider code written to CTRL[15:8]; CPOL, 1'b0, CTRL[1]; CPHA, 1'b0, CTRL[2]; TIMEOUT, 16'd4096, poll limit in clk cycles.
REQ-002 SHALL have ports (one clock; reset asynchronous, active-low): clk input 1, system clock; rst_n input 1, async active-low reset.
REQ-003 Request port: req_valid in 1, request present; req_ready out 1, accept; req_cmd in 8, command byte; req_addr in 24, address; req_addr_en in 1, send 3 address bytes; req_wr in 1, 1=data phase writes, 0=reads; req_len in 8, data bytes (0 = none).
REQ-004 Data ports: tx_valid in 1; tx_ready out 1; tx_data in 8, write byte; rx_valid out 1; rx_ready in 1; rx_data out 8, read byte.
REQ-005 Status: busy out 1, transaction active; done out 1, one-cycle end pulse; err out 1, one-cycle abort pulse.
REQ-006 SPI register master: spi_waddr_o out 8; spi_wdata_o out 32; spi_sel_o out 4; spi_we_o out 1; spi_raddr_o out 8; spi_rd_o out 1; spi_rdata_i in 32, read data valid one cycle after spi_rd_o.

Function
REQ-007 States SHALL be IDLE, LOAD, START, WAIT, POLL, FETCH, CS_OFF, FIN.
REQ-008 IDLE: req_ready=1; on req_valid&req_ready latch cmd/addr/addr_en/wr/len, phase=CMD, go LOAD.
REQ-009 Byte order: cmd; addr[23:16], [15:8], [7:0] if addr_en; then len data bytes; MSB-first handled by peripheral.
REQ-010 LOAD: one-cycle write of DATA (offset 0x04, sel 4'b0001) with current byte; write-data phase stalls in LOAD with tx_ready=1 until tx_valid; read-data phase sends 8'hFF.
REQ-011 START: one-cycle write of CTRL (offset 0x00, sel 4'b0011) with {16'h0, DIV, 3'b0, 1'b0, 1'b1, CPHA, CPOL, 1'b1}; spi_we_o SHALL be low the following cycle.
REQ-012 WAIT: fixed 3 cycles with no bus access, covering busy-flag latency.
REQ-013 POLL: pulse spi_rd_o at STATUS (0x08), sample spi_rdata_i[0] next cycle; repeat until sampled 0.
REQ-014 FETCH (read-data phase only): read DATA, capture [7:0] into rx_data, assert rx_valid, hold until rx_ready; rx_valid, rx_data stable while stalled.
REQ-015 After each byte: more bytes -> LOAD; else CS_OFF: one-cycle CTRL write with CS=0, EN=0; then FIN: done=1 one cycle, return IDLE.
REQ-016 CS (CTRL[3]) SHALL stay 1 across all bytes of one transaction.
REQ-017 req_len=0 with addr_en=0 SHALL transfer exactly one byte (cmd).
REQ-018 Byte counter 8 bits; last byte when count==req_len-1; no wrap for req_len=255.
REQ-019 spi_we_o and spi_rd_o SHALL never assert in the same cycle.
REQ-020 busy=1 in every state except IDLE.

Reset
REQ-021 On rst_n low, asynchronously: state=IDLE, req_ready=0 until first clk after release, tx_ready=0, rx_valid=0, rx_data=0, busy=0, done=0, err=0, spi_we_o=0, spi_rd_o=0, all addr/data/sel outputs 0.
REQ-022 Reset mid-transaction SHALL abandon it without CS_OFF write; peripheral shares rst_n.

Configuration
REQ-023 SPI_SEQ_TIMEOUT_EN defined: POLL counts cycles; reaching TIMEOUT -> CS_OFF, err=1 one cycle instead of done, rx_valid not asserted for that byte.
REQ-024 SPI_SEQ_TIMEOUT_EN undefined: no counter, POLL waits indefinitely, err tied 0.

Structure
REQ-025 Register offsets (0x00/0x04/0x08), CTRL bit positions, state and phase encodings SHALL live in the shared SPI defines include.
REQ-026 Single module; optional sub-module spi_seq_timer holds timeout counter, instantiated only under SPI_SEQ_TIMEOUT_EN.

Verification
REQ-027 cmd=8'h9F, addr_en=0, wr=0, len=3, slave returns EF 40 18 -> MOSI 9F FF FF FF, rx EF,40,18, done once, CS low 4 bytes.
REQ-028 cmd=8'h03, addr=24'h012345, addr_en=1, len=2 -> MOSI 03 01 23 45 FF FF, 6 CTRL start writes, one CS_OFF write.
REQ-029 cmd=8'h02, wr=1, len=2, tx_valid delayed 10 cycles -> LOAD stalls, MOSI 02 A5 5A, rx_valid never high.
REQ-030 rx_ready low 20 cycles on byte 1 -> rx_valid/rx_data held, no next LOAD until accepted.
REQ-031 SPI_SEQ_TIMEOUT_EN, STATUS forced 1, TIMEOUT=16 -> err pulse after 16 poll cycles, done=0, CS released.
REQ-032 rst_n low during POLL of byte 2 -> all outputs at reset values immediately; next request runs normally.
